// File: rtl/load_store_aligner.sv
// Load/store aligner: maps byte/half/word/double accesses onto a word-wide bus, splitting
// misaligned accesses into two beats and merging/extending the load result.
module load_store_aligner #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);
    localparam int unsigned W     = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(W);

    typedef enum logic [2:0] {StIdle, StBeat1, StWait1, StBeat2, StWait2, StResp} state_e;

    state_e            state_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              unsigned_q;
    logic              split_q;
    logic [DATA_W-1:0] wdata_hi_q;
    logic [W-1:0]      be_hi_q;
    logic [DATA_W-1:0] beat1_q;

    assign req_ready = (state_q == StIdle);

    // Request decode: legality plus the 2W-byte store lane vectors (low half = beat1).
    logic [OFF_W-1:0]    req_off;
    int unsigned         req_nbytes;
    logic                req_misaligned;
    logic                req_err;
    logic [2*DATA_W-1:0] wdata_shift;
    logic [2*DATA_W-1:0] data2;
    logic [2*W-1:0]      be2;

    always_comb begin
        req_off        = req_addr[OFF_W-1:0];
        req_nbytes     = 32'd1 << req_size;
        req_misaligned = (32'(req_off) + req_nbytes) > W;
        req_err        = (req_nbytes > W) || (req_misaligned && !SPLIT_EN);
        wdata_shift    = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
        for (int unsigned b = 0; b < 2 * W; b++) begin
            be2[b]          = (b >= 32'(req_off)) && (b < 32'(req_off) + req_nbytes);
            data2[8*b +: 8] = be2[b] ? wdata_shift[8*b +: 8] : 8'h00;
        end
    end

    // Load merge: the incoming beat is beat1 on an aligned access, beat2 otherwise.
    logic [DATA_W-1:0] merge_lo;
    logic [DATA_W-1:0] merge_hi;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_result;
    int unsigned       nbytes;
    logic              sign;

    always_comb begin
        merge_lo = (state_q == StWait2) ? beat1_q : bus_rdata;
        merge_hi = (state_q == StWait2) ? bus_rdata : '0;
        merged   = DATA_W'({merge_hi, merge_lo} >> {off_q, 3'b000});
        nbytes   = 32'd1 << size_q;
        sign     = 1'b0;
        for (int unsigned b = 0; b < W; b++) begin
            if (b + 1 == nbytes) sign = merged[8*b+7] & ~unsigned_q;
        end
        for (int unsigned b = 0; b < W; b++) begin
            load_result[8*b +: 8] = (b < nbytes) ? merged[8*b +: 8] : {8{sign}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            off_q      <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            split_q    <= 1'b0;
            wdata_hi_q <= '0;
            be_hi_q    <= '0;
            beat1_q    <= '0;
            bus_valid  <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        off_q      <= req_off;
                        size_q     <= req_size;
                        we_q       <= req_we;
                        unsigned_q <= req_unsigned;
                        split_q    <= req_misaligned;
                        wdata_hi_q <= data2[2*DATA_W-1:DATA_W];
                        be_hi_q    <= be2[2*W-1:W];
                        if (req_err) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state_q   <= StBeat1;
                            bus_valid <= 1'b1;
                            bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus_we    <= req_we;
                            bus_be    <= req_we ? be2[W-1:0] : '1;
                            bus_wdata <= req_we ? data2[DATA_W-1:0] : '0;
                        end
                    end
                end
                StBeat1: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state_q   <= StWait1;
                    end
                end
                StWait1: begin
                    if (bus_rvalid) begin
                        beat1_q <= bus_rdata;
                        if (split_q) begin
                            state_q   <= StBeat2;
                            bus_valid <= 1'b1;
                            bus_addr  <= bus_addr + ADDR_W'(W);
                            bus_be    <= we_q ? be_hi_q : '1;
                            bus_wdata <= we_q ? wdata_hi_q : '0;
                        end else begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_rdata <= we_q ? '0 : load_result;
                        end
                    end
                end
                StBeat2: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state_q   <= StWait2;
                    end
                end
                StWait2: begin
                    if (bus_rvalid) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? '0 : load_result;
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_aligner.sv
// Bench for load_store_aligner: directed table, reset/no-split sequences, and random
// accesses checked against a byte-addressed memory model.
module tb_load_store_aligner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        ns_req_valid, ns_req_ready, ns_req_we, ns_req_unsigned;
    logic [1:0]  ns_req_size;
    logic [31:0] ns_req_addr, ns_req_wdata;
    logic        ns_bus_valid, ns_bus_ready, ns_bus_we, ns_bus_rvalid;
    logic [31:0] ns_bus_addr, ns_bus_wdata, ns_bus_rdata;
    logic [3:0]  ns_bus_be;
    logic        ns_resp_valid, ns_resp_err;
    logic [31:0] ns_resp_rdata;

    load_store_aligner #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    load_store_aligner #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b0)) u_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
        .req_size(ns_req_size), .req_unsigned(ns_req_unsigned), .req_addr(ns_req_addr),
        .req_wdata(ns_req_wdata),
        .bus_valid(ns_bus_valid), .bus_ready(ns_bus_ready), .bus_addr(ns_bus_addr),
        .bus_we(ns_bus_we), .bus_be(ns_bus_be), .bus_wdata(ns_bus_wdata),
        .bus_rvalid(ns_bus_rvalid), .bus_rdata(ns_bus_rdata),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference memory and the word memory the bus responder serves.
    logic [7:0]  refmem [logic [31:0]];
    logic [31:0] busmem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] wa);
        logic [31:0] w;
        if (busmem.exists(wa)) return busmem[wa];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(wa + 32'(i));
        return w;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] val);
        busmem[wa] = val;
        for (int i = 0; i < 4; i++) refmem[wa + 32'(i)] = val[8*i +: 8];
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beats[$];
    beat_t       exp_beats[$];
    logic [31:0] m_rdata, act_rdata;
    logic        m_err, act_err;
    int          act_lat;

    // Model: walk the access byte by byte; each byte lands in the beat of its own word.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          nb, nbeats, k;
        logic [31:0] base, a, val;
        logic [1:0]  lane;
        beat_t       eb [2];
        nb = 1 << size;
        exp_beats.delete();
        m_rdata = '0;
        m_err   = (nb > 4);
        if (m_err) return;
        base   = {addr[31:2], 2'b00};
        nbeats = 1;
        val    = '0;
        for (int j = 0; j < 2; j++) begin
            eb[j].addr  = base + 32'(4 * j);
            eb[j].we    = we;
            eb[j].be    = we ? 4'h0 : 4'hF;
            eb[j].wdata = '0;
        end
        for (int i = 0; i < nb; i++) begin
            a    = addr + 32'(i);
            k    = (a[31:2] == base[31:2]) ? 0 : 1;
            lane = a[1:0];
            if (k == 1) nbeats = 2;
            if (we) begin
                eb[k].be[lane]           = 1'b1;
                eb[k].wdata[8*lane +: 8] = wdata[8*i +: 8];
                refmem[a]                = wdata[8*i +: 8];
            end else begin
                val[8*i +: 8] = ref_byte(a);
            end
        end
        if (!we && !uns && nb < 4 && val[8*nb-1])
            for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
        m_rdata = we ? 32'h0 : val;
        for (int j = 0; j < nbeats; j++) exp_beats.push_back(eb[j]);
    endtask

    // Drives one request and acts as the bus; stall = ready-low cycles per beat.
    task automatic do_access(input string name, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] wdata, input int stall);
        int    st;
        bit    pend, in_beat;
        beat_t snap;
        beats.delete();
        act_rdata = '0; act_err = 1'b0; act_lat = -1;
        pend = 0; in_beat = 0; st = stall; snap = '0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            req_valid  = 1'b0;
            bus_rvalid = 1'b0;
            bus_ready  = 1'b0;
            if (pend) begin
                bus_rvalid = 1'b1;
                bus_rdata  = snap.we ? $urandom : bus_word(snap.addr);
                pend       = 0;
            end
            if (resp_valid) begin
                act_rdata = resp_rdata; act_err = resp_err; act_lat = cyc;
                break;
            end
            if (bus_valid) begin
                if (!in_beat) begin
                    snap.addr = bus_addr; snap.we = bus_we; snap.be = bus_be;
                    snap.wdata = bus_wdata; in_beat = 1; st = stall;
                end else begin
                    check({name, " stall addr"}, bus_addr, snap.addr);
                    check({name, " stall be"}, {bus_we, bus_be}, {snap.we, snap.be});
                    check({name, " stall wdata"}, bus_wdata, snap.wdata);
                end
                if (st == 0) begin
                    bus_ready = 1'b1;
                    beats.push_back(snap);
                    if (snap.we) begin
                        busmem[snap.addr] = (bus_word(snap.addr) & ~lane_mask(snap.be)) |
                                            (snap.wdata & lane_mask(snap.be));
                    end
                    pend = 1; in_beat = 0;
                end else begin
                    st--;
                end
            end
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        if (act_lat < 0) check({name, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic exercise(input string name, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input int stall);
        int exp_lat;
        model(we, size, uns, addr, wdata);
        exp_lat = m_err ? 1 : (exp_beats.size() == 1 ? 3 + stall : 5 + 2 * stall);
        do_access(name, we, size, uns, addr, wdata, stall);
        check({name, " rdata"}, act_rdata, m_rdata);
        check({name, " err"}, 32'(act_err), 32'(m_err));
        check({name, " latency"}, act_lat, exp_lat);
        check({name, " nbeats"}, beats.size(), exp_beats.size());
        for (int i = 0; i < beats.size() && i < exp_beats.size(); i++) begin
            check({name, " beat addr"}, beats[i].addr, exp_beats[i].addr);
            check({name, " beat we/be"}, {beats[i].we, beats[i].be},
                  {exp_beats[i].we, exp_beats[i].be});
            if (exp_beats[i].we)
                check({name, " beat wdata"}, beats[i].wdata & lane_mask(exp_beats[i].be),
                      exp_beats[i].wdata);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata, m0, m1, exp_rdata;
        logic        exp_err;
        int          stall, exp_lat;
        logic [3:0]  exp_be1;
        logic [31:0] exp_wd1;
    } vec_t;

    vec_t vecs[$];

    task automatic ns_case(input string name, input logic [1:0] size, input logic [31:0] addr,
                           input logic exp_err, input logic [31:0] rdata,
                           input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_size = size; ns_req_addr = addr;
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        check({name, " c1 resp_valid"}, 32'(ns_resp_valid), 32'(exp_err));
        check({name, " c1 resp_err"}, 32'(ns_resp_err), 32'(exp_err));
        check({name, " c1 resp_rdata"}, ns_resp_rdata, 32'h0);
        check({name, " c1 bus_valid"}, 32'(ns_bus_valid), 32'(!exp_err));
        if (!exp_err) begin
            @(posedge clk); #1;
            ns_bus_rvalid = 1'b1; ns_bus_rdata = rdata;
            @(posedge clk); #1;
            ns_bus_rvalid = 1'b0;
            check({name, " resp_valid"}, 32'(ns_resp_valid), 32'd1);
            check({name, " resp_err"}, 32'(ns_resp_err), 32'd0);
            check({name, " resp_rdata"}, ns_resp_rdata, exp_rdata);
        end
        @(posedge clk); #1;
        check({name, " after resp_valid"}, 32'(ns_resp_valid), 32'd0);
        check({name, " after req_ready"}, 32'(ns_req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        ns_req_valid = 0; ns_req_we = 0; ns_req_size = 0; ns_req_unsigned = 0;
        ns_req_addr = 0; ns_req_wdata = 0;
        ns_bus_ready = 1'b1; ns_bus_rvalid = 0; ns_bus_rdata = 0;

        //      name        we    sz  uns  addr          wdata         m0            m1            rdata         err  stl lat be    wd1
        vecs.push_back('{"lb_sext",   1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0, 32'hFFFFFF80, 1'b0, 0, 3, 4'hF, 32'h0});
        vecs.push_back('{"lbu",       1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0, 32'h00000080, 1'b0, 0, 3, 4'hF, 32'h0});
        vecs.push_back('{"sh",        1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 0, 3, 4'hC, 32'hBEEF0000});
        vecs.push_back('{"lw_split",  1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 32'h44332211, 32'h88776655, 32'h77665544, 1'b0, 0, 5, 4'hF, 32'h0});
        vecs.push_back('{"sw_split",  1'b1, 2'd2, 1'b0, 32'h102, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b0, 0, 5, 4'hC, 32'hCCDD0000});
        vecs.push_back('{"sw_stall",  1'b1, 2'd2, 1'b0, 32'h102, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b0, 3, 11, 4'hC, 32'hCCDD0000});
        vecs.push_back('{"lh_sext",   1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80010000, 32'h0, 32'hFFFF8001, 1'b0, 0, 3, 4'hF, 32'h0});
        vecs.push_back('{"lhu_split", 1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 32'h00008811, 1'b0, 0, 5, 4'hF, 32'h0});
        vecs.push_back('{"lh_split",  1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 32'hFFFF8811, 1'b0, 0, 5, 4'hF, 32'h0});
        vecs.push_back('{"size3",     1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 1, 4'h0, 32'h0});
        vecs.push_back('{"lw_aligned",1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 0, 3, 4'hF, 32'h0});
        vecs.push_back('{"lw_wrap",   1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'hDEF01234, 1'b0, 0, 5, 4'hF, 32'h0});
        vecs.push_back('{"sb_lane3",  1'b1, 2'd0, 1'b0, 32'h107, 32'h123456A5, 32'h0, 32'h0, 32'h0, 1'b0, 0, 3, 4'h8, 32'hA5000000});

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst bus_valid", 32'(bus_valid), 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst bus_we/be", {bus_we, bus_be}, 32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        check("rst resp", {resp_valid, resp_err}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst req_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            preload({vecs[i].addr[31:2], 2'b00}, vecs[i].m0);
            preload({vecs[i].addr[31:2], 2'b00} + 32'd4, vecs[i].m1);
            exercise(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                     vecs[i].wdata, vecs[i].stall);
            check({vecs[i].name, " tbl rdata"}, act_rdata, vecs[i].exp_rdata);
            check({vecs[i].name, " tbl err"}, 32'(act_err), 32'(vecs[i].exp_err));
            check({vecs[i].name, " tbl lat"}, act_lat, vecs[i].exp_lat);
            if (!vecs[i].exp_err && beats.size() > 0) begin
                check({vecs[i].name, " tbl be1"}, 32'(beats[0].be), 32'(vecs[i].exp_be1));
                if (vecs[i].we)
                    check({vecs[i].name, " tbl wd1"},
                          beats[0].wdata & lane_mask(vecs[i].exp_be1), vecs[i].exp_wd1);
            end
        end

        // Reset while waiting for beat1 completion; late rvalid must be ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_ready = 1'b1;
        check("rstw c1 bus_valid", 32'(bus_valid), 32'd1);
        @(posedge clk); #1;
        bus_ready = 1'b0; rst = 1'b1;
        check("rstw c2 bus_valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE0000;
        check("rstw bus_valid", 32'(bus_valid), 32'd0);
        check("rstw resp_valid", 32'(resp_valid), 32'd0);
        check("rstw req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        check("rstw late rvalid", {resp_valid, bus_valid}, 32'd0);
        @(posedge clk); #1;
        check("rstw quiet", 32'(resp_valid), 32'd0);
        check("rstw req_ready2", 32'(req_ready), 32'd1);
        preload(32'h100, 32'h0BADF00D);
        exercise("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
        check("post_rst_lw value", act_rdata, 32'h0BADF00D);

        // Misaligned with splitting disabled, illegal size, and an aligned access.
        ns_case("ns_lh_mis", 2'd1, 32'h103, 1'b1, 32'h0, 32'h0);
        ns_case("ns_size3", 2'd3, 32'h100, 1'b1, 32'h0, 32'h0);
        ns_case("ns_lh_ok", 2'd1, 32'h102, 1'b0, 32'h80010000, 32'hFFFF8001);

        // Random accesses against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'h200 + 32'($urandom_range(0, 31));
            exercise($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom_range(0, 3)),
                     1'($urandom), a, $urandom, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_aligner.md
# load_store_aligner

Parametrised memory-access aligner between the execute stage and the word-wide data bus. It extends the byte immediate/extract path to byte/half/word (and double when DATA_W=64) loads and stores, with sign or zero extension and byte-enable generation. It splits misaligned accesses into two bus beats and merges the results. It handles one access at a time with valid/ready handshakes on both sides.

## Interface
- DATA_W, 32, bus and register width; 32 or 64.
- ADDR_W, 32, address width.
- SPLIT_EN, 1, 1: split misaligned accesses into two beats; 0: flag misaligned accesses as errors.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- bus_valid  out  1  bus beat request.
- bus_ready  in  1  bus accepts the beat.
- bus_addr  out  ADDR_W  word-aligned beat address.
- bus_we  out  1  beat is a write.
- bus_be  out  DATA_W/8  byte enables.
- bus_wdata  out  DATA_W  lane-aligned write data.
- bus_rvalid  in  1  beat completion; asserted for reads and writes.
- bus_rdata  in  DATA_W  read data, valid with bus_rvalid.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal size, or misaligned access with SPLIT_EN=0.

## Operation
- Definitions:
  - W = DATA_W/8.
  - off = req_addr mod W.
  - nbytes = 1 << req_size.
- Legality:
  - Illegal if nbytes > W.
  - Misaligned if off + nbytes > W.
  - Illegal size, or misaligned with SPLIT_EN=0: no bus activity; resp_valid=1, resp_err=1, resp_rdata=0 on the cycle after acceptance.
- States: IDLE, BEAT1, WAIT1, BEAT2, WAIT2, RESP.
  - IDLE: on req_valid & req_ready, latch the request. Go to BEAT1, or to RESP on error.
  - BEAT1: bus_valid=1. On bus_ready, go to WAIT1.
  - WAIT1: on bus_rvalid, latch rdata into beat1. If misaligned, go to BEAT2; otherwise go to RESP.
  - BEAT2: bus_valid=1. On bus_ready, go to WAIT2.
  - WAIT2: on bus_rvalid, latch beat2 and go to RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE.
- Beat addresses:
  - Beat1: bus_addr = req_addr with the low log2(W) bits cleared.
  - Beat2: beat1 address + W; wraps modulo 2^ADDR_W.
- Store lanes:
  - Form 2W-byte vectors: data2 = req_wdata << (8·off), be2 = ((1<<nbytes)-1) << off.
  - Beat1 uses the low W bytes of each vector; beat2 uses the high W bytes.
- Load merge:
  - merged = {beat2, beat1} >> (8·off); beat2 is 0 when aligned.
  - Take the low nbytes bytes. Sign-extend from bit 8·nbytes−1 unless req_unsigned=1 or nbytes=W.
- All bus_* outputs stay stable from bus_valid assertion until bus_ready.
- bus_rvalid outside WAIT1/WAIT2 is ignored.

## Timing
- Reset values:
  - bus_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - State IDLE, so req_ready=1 on the cycle after rst drops.
- rst in any state returns to IDLE the next cycle and drops bus_valid/resp_valid. The bus is reset in the same cycle, so outstanding beats are discarded.
- Aligned access, zero-wait bus (bus_ready=1, rvalid one cycle after acceptance):
  - Cycle 0: accept.
  - Cycle 1: bus_valid.
  - Cycle 2: bus_rvalid.
  - Cycle 3: resp_valid.
- Misaligned access on the same bus: resp_valid on cycle 5.
- Error path: resp_valid on cycle 1.
- req_ready is combinational from state (IDLE only). A new request may be accepted on the cycle after resp_valid.
- resp_rdata and resp_err are registered and valid only while resp_valid=1; they return to 0 otherwise.

## Test plan
- LB addr 0x103, bus_rdata 0x80123456 -> bus_addr 0x100, bus_be 0xF, resp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102, wdata 0x0000BEEF -> one beat: bus_addr 0x100, bus_be 0xC, bus_wdata 0xBEEF0000, bus_we=1. resp_rdata 0.
- LW addr 0x103, beats 0x44332211 (at 0x100) and 0x88776655 (at 0x104) -> resp_rdata 0x77665544, resp_valid on cycle 5.
- SW addr 0x102, wdata 0xAABBCCDD -> beat1: 0x100 / be 0xC / 0xCCDD0000. Beat2: 0x104 / be 0x3 / 0x0000AABB. Hold bus_ready low 3 cycles on beat1 -> all bus_* stable.
- SPLIT_EN=0, LH addr 0x103 -> no bus_valid, resp_err=1 on cycle 1. req_size=3 with DATA_W=32 -> same result.
- Assert rst during WAIT1 -> IDLE next cycle, bus_valid=0, no resp_valid. A late bus_rvalid is ignored, and the next aligned LW completes normally.
